jtframe_prog_packer: RTL and testbench
======================================

// Module: jtframe_prog_packer
// PURPOSE
//  Parametrised successor to the byte-wide ROM download path. Sits between hps_io (ioctl_*)
//  and the SDRAM programming port (prog_*). Drops HEADER bytes and packs bytes into DW-wide
//  words with per-lane masks, coalescing adjacent bytes. Buffers words in a FIFO drained via
//  a prog_we/prog_rdy handshake. Holds dwnld_busy until all data is written.
// PARAMETERS
//  AW     22  ioctl byte-address width
//  DW     16  prog data width; legal values 8, 16, 32
//  HEADER 0   leading bytes discarded (ioctl_addr < HEADER)
//  SWAB   0   1: reverse byte-lane order within a word
//  DEPTH  4   FIFO entries; power of two, >=2
// PORTS
//  clk_sys        in   1          single clock
//  rst_n          in   1          asynchronous, active-low reset
//  ioctl_download in   1          download window
//  ioctl_addr     in   AW         byte address
//  ioctl_data     in   8          byte data
//  ioctl_wr       in   1          one-cycle byte strobe
//  prog_addr      out  AW-LB      word address; LB=log2(DW/8)
//  prog_data      out  DW         word data
//  prog_mask      out  DW/8       active-low lane enable; 0 = lane written
//  prog_we        out  1          entry valid; held until prog_rdy
//  prog_rdy       in   1          SDRAM side accepts entry this cycle
//  dwnld_busy     out  1          download window open or data still pending
//  overflow       out  1          sticky; a word was lost because the FIFO was full
// BEHAVIOUR
//  Reset values: prog_we=0, prog_addr=0, prog_data=0, prog_mask=all-1, dwnld_busy=0,
//   overflow=0. FIFO is empty, no partial word is held, and the FSM is in IDLE.
//  Accepted byte: ioctl_wr=1 && ioctl_download=1 && ioctl_addr>=HEADER. Other bytes are ignored.
//  Address math: ea=ioctl_addr-HEADER. word=ea>>LB. lane=ea[LB-1:0], XOR all-ones if SWAB.
//   The byte goes to data[8*lane+:8] and clears mask[lane].
//  Partial-word register (P): holds word address, data and mask.
//  FSM IDLE -> FILL:
//   On the rising edge of ioctl_download, clear overflow.
//   The first accepted byte loads P.
//  FSM FILL, accepted byte:
//   Same word: merge into P. A repeated lane overwrites the earlier byte.
//   Different word: push P, then load P with the new byte, in the same cycle.
//   Merge that completes all lanes: push the merged word and empty P.
//   DW=8: every accepted byte pushes directly; P is never used.
//  FSM FILL -> DRAIN on falling ioctl_download. If P is non-empty, push P that cycle.
//  FSM DRAIN -> IDLE when the FIFO is empty.
//  A new rising edge of ioctl_download while in DRAIN returns to FILL; the FIFO keeps draining.
//  Push timing: a push occurs at the clock edge that samples ioctl_wr. The entry is visible
//   on prog_* with prog_we=1 from the next cycle (1-cycle latency).
//  FIFO output is show-ahead: prog_* stay stable while prog_we=1 && prog_rdy=0.
//   Pop happens on prog_we && prog_rdy.
//  A push and a pop in the same cycle are legal at any fill level, including full.
//  Push while full without a same-cycle pop: drop the entry and set overflow (sticky).
//   Existing entries are unchanged.
//  dwnld_busy = ioctl_download | P valid | FIFO non-empty. It is registered and falls the
//   cycle after the last pop.
//  Address wrap-around: word addresses wrap mod 2^(AW-LB) with no special handling.
//  Asynchronous reset mid-download: all state is cleared immediately; in-flight data is lost.
// STRUCTURE
//  Package jtframe_prog_pkg:
//   - typedef prog_entry_t {addr, data, mask}
//   - enum {IDLE, FILL, DRAIN}
//   - function lane_of(ea, swab)
//  Sub-module jtframe_prog_fifo: synchronous show-ahead FIFO of prog_entry_t, DEPTH entries,
//   with full/empty flags and simultaneous push/pop. The packer holds P, the FSM and the flags.
// TESTING
//  1. DW=16, HEADER=0; bytes 0x11@0, 0x22@1, prog_rdy=1 -> a single write of addr 0,
//     data 0x2211, mask 2'b00, one cycle after the second byte.
//  2. DW=16, HEADER=4; bytes @0..5 = 0xA0..0xA5 -> bytes @0..3 are dropped; a single write of
//     addr 0, data 0xA5A4.
//  3. DW=32, SWAB=1; a lone byte 0x5A@6, then download falls ->
//     - flush write: addr 1, data 0x00005A00, mask 4'b1101
//     - dwnld_busy drops after the pop.
//  4. DW=16, DEPTH=4, prog_rdy=0; 10 byte-pairs sent ->
//     - the first 4 words are kept in order
//     - overflow=1
//     - after prog_rdy=1, exactly 4 writes occur, then dwnld_busy=0.
//  5. Non-adjacent bytes 0x01@2, then 0x02@9 (DW=16) -> two writes:
//     - addr 1, data 0x0001, mask 2'b10
//     - addr 4, data 0x0200, mask 2'b01
//  6. Drive rst_n low while 2 FIFO entries are pending -> prog_we=0 and dwnld_busy=0 at once;
//     no write occurs after release.

Source files
------------

// File: rtl/jtframe_prog_pkg.sv
// jtframe_prog_pkg: shared types and lane helper for the ROM programming packer
package jtframe_prog_pkg;

    localparam int MAX_AW = 32;
    localparam int MAX_DW = 32;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    typedef struct packed {
        logic [MAX_AW-1:0]   addr;
        logic [MAX_DW-1:0]   data;
        logic [MAX_DW/8-1:0] mask;
    } prog_entry_t;

    function automatic logic [1:0] lane_of(input logic [1:0] ea, input logic swab, input int lb);
        logic [1:0] m;
        m = 2'((1 << lb) - 1);
        return (ea ^ (swab ? m : 2'b00)) & m;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// jtframe_prog_fifo: show-ahead FIFO of programming entries with simultaneous push/pop
module jtframe_prog_fifo
    import jtframe_prog_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = prog_entry_t
)(
    input  logic clk_sys,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty,
    output logic nxt_empty
);
    localparam int PW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic        wr_en, rd_en;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign nxt_empty = wr_nxt == rd_nxt;
    assign dout      = mem[rd_ptr[PW-1:0]];

    // a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        rd_en  = pop & ~empty;
        wr_en  = push & (~full | rd_en);
        wr_nxt = wr_ptr + {{PW{1'b0}}, wr_en};
        rd_nxt = rd_ptr + {{PW{1'b0}}, rd_en};
    end

    // pointer registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    // storage needs no reset: the head is only looked at while non-empty
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// jtframe_prog_packer: packs ioctl download bytes into masked SDRAM words through a FIFO
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter int AW     = 22,
    parameter int DW     = 16,
    parameter int HEADER = 0,
    parameter int SWAB   = 0,
    parameter int DEPTH  = 4
)(
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               ioctl_download,
    input  logic [AW-1:0]      ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [AW-$clog2(DW/8)-1:0] prog_addr,
    output logic [DW-1:0]      prog_data,
    output logic [DW/8-1:0]    prog_mask,
    output logic               prog_we,
    input  logic               prog_rdy,
    output logic               dwnld_busy,
    output logic               overflow
);
    localparam int LB = $clog2(DW/8);
    localparam int NL = DW/8;
    localparam int WA = AW - LB;

    typedef struct packed {
        logic [WA-1:0] addr;
        logic [DW-1:0] data;
        logic [NL-1:0] mask;
    } entry_t;

    state_t      state, state_nxt;
    entry_t      p, p_nxt, base, merged, push_entry, head;
    logic        p_valid, p_valid_nxt, dl_q, rise, fall, acc, flush, same;
    logic        push_old, push_new, push, pop, drop, full, empty, nxt_empty;
    logic [AW:0] diff;
    logic [1:0]  lane;

    // byte qualification: the header is skipped by the borrow of the offset subtraction
    always_comb begin
        diff = {1'b0, ioctl_addr} - (AW+1)'(HEADER);
        acc  = ioctl_wr & ioctl_download & ~diff[AW];
        lane = lane_of(diff[1:0], SWAB != 0, LB);
        rise = ioctl_download & ~dl_q;
        fall = ~ioctl_download & dl_q;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = FILL;
            FILL:    if (fall) state_nxt = DRAIN;
            DRAIN:   state_nxt = rise ? FILL : (empty ? IDLE : DRAIN);
            default: state_nxt = IDLE;
        endcase
    end

    // merge the byte into the partial word, deciding which word (old or merged) is pushed
    always_comb begin
        flush  = (state == FILL) & fall & p_valid;
        same   = p_valid & (p.addr == diff[AW-1:LB]);
        base   = same ? p : entry_t'{addr: diff[AW-1:LB], data: '0, mask: '1};
        merged = base;
        for (int i = 0; i < NL; i++) begin
            if (lane == 2'(i)) begin
                merged.data[8*i +: 8] = ioctl_data;
                merged.mask[i]        = 1'b0;
            end
        end
        push_old    = flush | (acc & p_valid & ~same);
        push_new    = acc & ~|merged.mask;
        push        = push_old | push_new;
        push_entry  = push_old ? p : merged;
        p_nxt       = acc ? merged : p;
        p_valid_nxt = acc ? ~push_new : (flush ? 1'b0 : p_valid);
        pop         = prog_we & prog_rdy;
        drop        = push & full & ~pop;
    end

    // state, partial word and status flags
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            p          <= '0;
            p_valid    <= 1'b0;
            overflow   <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            state      <= state_nxt;
            dl_q       <= ioctl_download;
            p          <= p_nxt;
            p_valid    <= p_valid_nxt;
            overflow   <= drop ? 1'b1 : (rise ? 1'b0 : overflow);
            dwnld_busy <= ioctl_download | p_valid_nxt | ~nxt_empty;
        end
    end

    jtframe_prog_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (push_entry),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .nxt_empty (nxt_empty)
    );

    assign prog_we   = ~empty;
    assign prog_addr = prog_we ? head.addr : '0;
    assign prog_data = prog_we ? head.data : '0;
    assign prog_mask = prog_we ? head.mask : '1;

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// tb_jtframe_prog_packer: directed checks of the packer in 8/16/32-bit and header configurations
module tb_jtframe_prog_packer;

    logic        clk_sys = 0;
    logic        rst_n = 0;
    logic        ioctl_download = 0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 0;
    logic        prog_rdy = 1;

    logic [20:0] a16, a16h;
    logic [15:0] d16, d16h;
    logic [1:0]  m16, m16h;
    logic        we16, busy16, ov16, we16h, busy16h, ov16h;
    logic [19:0] a32;
    logic [31:0] d32;
    logic [3:0]  m32;
    logic        we32, busy32, ov32;
    logic [21:0] a8;
    logic [7:0]  d8;
    logic [0:0]  m8;
    logic        we8, busy8, ov8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    jtframe_prog_packer #(.AW(22), .DW(16), .HEADER(0), .SWAB(0), .DEPTH(4)) u16 (
        .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(a16), .prog_data(d16), .prog_mask(m16),
        .prog_we(we16), .prog_rdy(prog_rdy), .dwnld_busy(busy16), .overflow(ov16));

    jtframe_prog_packer #(.AW(22), .DW(16), .HEADER(4), .SWAB(0), .DEPTH(4)) u16h (
        .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(a16h), .prog_data(d16h), .prog_mask(m16h),
        .prog_we(we16h), .prog_rdy(prog_rdy), .dwnld_busy(busy16h), .overflow(ov16h));

    jtframe_prog_packer #(.AW(22), .DW(32), .HEADER(0), .SWAB(1), .DEPTH(4)) u32 (
        .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(a32), .prog_data(d32), .prog_mask(m32),
        .prog_we(we32), .prog_rdy(prog_rdy), .dwnld_busy(busy32), .overflow(ov32));

    jtframe_prog_packer #(.AW(22), .DW(8), .HEADER(0), .SWAB(0), .DEPTH(4)) u8 (
        .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(a8), .prog_data(d8), .prog_mask(m8),
        .prog_we(we8), .prog_rdy(prog_rdy), .dwnld_busy(busy8), .overflow(ov8));

    typedef struct {
        logic [21:0] a0;
        logic [7:0]  d0;
        logic [21:0] a1;
        logic [7:0]  d1;
        logic [20:0] ea;
        logic [15:0] ed;
        logic [1:0]  em;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [21:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1;
        @(negedge clk_sys);
        ioctl_wr   = 0;
    endtask

    task automatic do_reset;
        rst_n          = 0;
        ioctl_download = 0;
        ioctl_wr       = 0;
        prog_rdy       = 1;
        repeat (2) @(negedge clk_sys);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] lo, hi;
        tbl[0] = '{22'd0,      8'h11, 22'd1,      8'h22, 21'd0,      16'h2211, 2'b00};
        tbl[1] = '{22'd3,      8'h33, 22'd2,      8'h44, 21'd1,      16'h3344, 2'b00};
        tbl[2] = '{22'd8,      8'hFF, 22'd9,      8'h00, 21'd4,      16'h00FF, 2'b00};
        tbl[3] = '{22'h3FFFFE, 8'h01, 22'h3FFFFF, 8'h02, 21'h1FFFFF, 16'h0201, 2'b00};
        tbl[4] = '{22'd7,      8'hC3, 22'd6,      8'h3C, 21'd3,      16'hC33C, 2'b00};

        do_reset();
        chk("rst_we", we16, 0);
        chk("rst_addr", a16, 0);
        chk("rst_data", d16, 0);
        chk("rst_mask", m16, 2'b11);
        chk("rst_busy", busy16, 0);
        chk("rst_ovf", ov16, 0);

        // table: byte pairs completing one 16-bit word each, drained immediately
        @(negedge clk_sys) ioctl_download = 1;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].a0, tbl[i].d0);
            chk("tbl_we_first", we16, 0);
            chk("tbl_w8_addr", a8, tbl[i].a0);
            chk("tbl_w8_data", d8, tbl[i].d0);
            send(tbl[i].a1, tbl[i].d1);
            chk("tbl_we", we16, 1);
            chk("tbl_addr", a16, tbl[i].ea);
            chk("tbl_data", d16, tbl[i].ed);
            chk("tbl_mask", m16, tbl[i].em);
            chk("tbl_w8_data2", d8, tbl[i].d1);
            chk("tbl_busy", busy16, 1);
        end

        // repeated lane overwrites the earlier byte
        send(22'd4, 8'hAA);
        send(22'd4, 8'hBB);
        chk("ovw_we_mid", we16, 0);
        send(22'd5, 8'hCC);
        chk("ovw_we", we16, 1);
        chk("ovw_addr", a16, 2);
        chk("ovw_data", d16, 16'hCCBB);

        // non-adjacent bytes: word change pushes, falling download flushes
        do_reset();
        @(negedge clk_sys) ioctl_download = 1;
        send(22'd2, 8'h01);
        chk("na_we0", we16, 0);
        send(22'd9, 8'h02);
        chk("na_we1", we16, 1);
        chk("na_addr1", a16, 1);
        chk("na_data1", d16, 16'h0001);
        chk("na_mask1", m16, 2'b10);
        @(negedge clk_sys) ioctl_download = 0;
        @(negedge clk_sys);
        chk("na_we2", we16, 1);
        chk("na_addr2", a16, 4);
        chk("na_data2", d16, 16'h0200);
        chk("na_mask2", m16, 2'b01);
        @(negedge clk_sys);
        chk("na_done_we", we16, 0);
        chk("na_done_busy", busy16, 0);

        // header bytes dropped
        do_reset();
        @(negedge clk_sys) ioctl_download = 1;
        for (int i = 0; i < 5; i++) begin
            send(22'(i), 8'hA0 + 8'(i));
            chk("hdr_we_none", we16h, 0);
        end
        send(22'd5, 8'hA5);
        chk("hdr_we", we16h, 1);
        chk("hdr_addr", a16h, 0);
        chk("hdr_data", d16h, 16'hA5A4);
        chk("hdr_mask", m16h, 2'b00);

        // 32-bit swapped lone byte flushed on falling download
        do_reset();
        @(negedge clk_sys) ioctl_download = 1;
        send(22'd6, 8'h5A);
        chk("sw_we0", we32, 0);
        @(negedge clk_sys) ioctl_download = 0;
        @(negedge clk_sys);
        chk("sw_we", we32, 1);
        chk("sw_addr", a32, 1);
        chk("sw_data", d32, 32'h00005A00);
        chk("sw_mask", m32, 4'b1101);
        chk("sw_busy", busy32, 1);
        @(negedge clk_sys);
        chk("sw_we_after", we32, 0);
        chk("sw_busy_after", busy32, 0);

        // overflow with prog_rdy held low
        do_reset();
        prog_rdy = 0;
        @(negedge clk_sys) ioctl_download = 1;
        for (int k = 0; k < 10; k++) begin
            send(22'(2*k), 8'h10 + 8'(k));
            send(22'(2*k+1), 8'h20 + 8'(k));
        end
        @(negedge clk_sys) ioctl_download = 0;
        @(negedge clk_sys);
        chk("ovf_flag", ov16, 1);
        chk("ovf_busy", busy16, 1);
        chk("ovf_we", we16, 1);
        prog_rdy = 1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (we16) begin
                lo = 8'h10 + 8'(n);
                hi = 8'h20 + 8'(n);
                chk("ovf_addr", a16, 32'(n));
                chk("ovf_data", d16, {hi, lo});
                n++;
            end
            @(negedge clk_sys);
        end
        chk("ovf_count", n, 4);
        chk("ovf_busy_end", busy16, 0);
        chk("ovf_sticky", ov16, 1);
        @(negedge clk_sys) ioctl_download = 1;
        @(negedge clk_sys);
        chk("ovf_clear", ov16, 0);
        ioctl_download = 0;

        // asynchronous reset with pending entries
        do_reset();
        prog_rdy = 0;
        @(negedge clk_sys) ioctl_download = 1;
        send(22'd0, 8'h01);
        send(22'd1, 8'h02);
        send(22'd2, 8'h03);
        send(22'd3, 8'h04);
        chk("ar_we_before", we16, 1);
        @(negedge clk_sys);
        #2 rst_n = 0;
        #1;
        chk("ar_we", we16, 0);
        chk("ar_busy", busy16, 0);
        ioctl_download = 0;
        repeat (2) @(negedge clk_sys);
        rst_n = 1;
        prog_rdy = 1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_sys);
            if (we16) n++;
        end
        chk("ar_no_write", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
